// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and the per-operation context latched at launch.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIN  = 2'b10
    } state_e;

    typedef struct packed {
        op_e  op;
        logic a_neg;
        logic b_neg;
        logic b_zero;
    } op_ctx_t;

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiplier / restoring divider sharing one 2*WIDTH accumulator.
// Optional MULDIV_EARLY_TERM_EN: multiply exits once remaining multiplier bits are zero.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               is_div_i,
    input  logic [WIDTH-1:0]   a_mag_i,
    input  logic [WIDTH-1:0]   b_mag_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic [CNT_W-1:0]   cnt_o,
    output logic               skip_o
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               div_q, div_d;

    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] div_step;

    // Multiply: acc = {partial product, unconsumed multiplier bits}, shifting right.
    always_comb begin
        mul_addend = acc_q[0] ? opnd_q : '0;
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
        mul_step   = {mul_sum, acc_q[WIDTH-1:1]};
    end

    // Divide: acc = {remainder, dividend/quotient}, shifting left one bit per step.
    always_comb begin
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        if (div_ge) begin
            div_step = {div_diff, acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_step = {acc_q[2*WIDTH-2:0], 1'b0};
        end
    end

`ifdef MULDIV_EARLY_TERM_EN
    logic [WIDTH-1:0] rem_mask;
    assign rem_mask = ~({WIDTH{1'b1}} << cnt_q);
    assign skip_o   = !div_q && ((acc_q[WIDTH-1:0] & rem_mask) == '0);
`else
    assign skip_o   = 1'b0;
`endif

    always_comb begin
        acc_d  = acc_q;
        opnd_d = opnd_q;
        cnt_d  = cnt_q;
        div_d  = div_q;
        if (load_i) begin
            div_d  = is_div_i;
            opnd_d = is_div_i ? b_mag_i : a_mag_i;
            acc_d  = {{WIDTH{1'b0}}, (is_div_i ? a_mag_i : b_mag_i)};
            cnt_d  = CNT_W'(WIDTH);
        end else if (step_i) begin
            if (skip_o) begin
                // No adds remain, so the outstanding right shifts collapse into one.
                acc_d = acc_q >> cnt_q;
                cnt_d = '0;
            end else begin
                acc_d = div_q ? div_step : mul_step;
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q  <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            div_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
            div_q  <= div_d;
        end
    end

    assign acc_o = acc_q;
    assign cnt_o = cnt_q;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO, MTHI/MTLO, flush and busy.
// Build option MULDIV_EARLY_TERM_EN (see muldiv_datapath) shortens multiplies.
module mul_div_unit
    import muldiv_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    state_e             state_q, state_d;
    op_ctx_t            ctx_q, ctx_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;

    op_e                op_in;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               load, step, fin_we, div_by_zero;

    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic               skip;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, dividend;

    // Operand conditioning: magnitudes and signs for the unsigned core.
    always_comb begin
        op_in = op_e'(op_i);
        a_neg = op_is_signed(op_in) && a_i[WIDTH-1];
        b_neg = op_is_signed(op_in) && b_i[WIDTH-1];
        a_mag = a_neg ? -a_i : a_i;
        b_mag = b_neg ? -b_i : b_i;
    end

    muldiv_datapath #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_datapath (
        .clk_i    (clk_i),
        .rst_i    (reset_i),
        .load_i   (load),
        .step_i   (step),
        .is_div_i (op_is_div(op_in)),
        .a_mag_i  (a_mag),
        .b_mag_i  (b_mag),
        .acc_o    (acc),
        .cnt_o    (cnt),
        .skip_o   (skip)
    );

    assign div_by_zero = op_is_div(ctx_q.op) && ctx_q.b_zero;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i && !flush_i) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (div_by_zero || skip || (cnt == CNT_W'(1))) begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q != IDLE);
        load   = (state_q == IDLE) && start_i && !flush_i;
        step   = (state_q == CALC) && !flush_i && !div_by_zero;
        fin_we = (state_q == FIN) && !flush_i;
    end

    // Sign correction. A divide-by-zero never steps, so acc still holds {0, |a|}.
    always_comb begin
        prod     = (ctx_q.a_neg ^ ctx_q.b_neg) ? -acc : acc;
        quo      = (ctx_q.a_neg ^ ctx_q.b_neg) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem      = ctx_q.a_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        dividend = ctx_q.a_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end

    always_comb begin
        ctx_d = ctx_q;
        if (load) begin
            ctx_d.op     = op_in;
            ctx_d.a_neg  = a_neg;
            ctx_d.b_neg  = b_neg;
            ctx_d.b_zero = (b_i == '0);
        end
    end

    always_comb begin
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
        done_d     = fin_we;
        if (state_q == IDLE) begin
            if (hi_we_i) hi_d = wdata_i;
            if (lo_we_i) lo_d = wdata_i;
        end
        if (fin_we) begin
            if (!op_is_div(ctx_q.op)) begin
                hi_d = prod[2*WIDTH-1:WIDTH];
                lo_d = prod[WIDTH-1:0];
            end else if (ctx_q.b_zero) begin
                hi_d       = dividend;
                lo_d       = '1;
                div_zero_d = 1'b1;
            end else begin
                hi_d       = rem;
                lo_d       = quo;
                div_zero_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ctx_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            ctx_q      <= ctx_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign done_o     = done_q;
    assign div_zero_o = div_zero_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit (WIDTH=32, default build): expected results are
// queued at launch and popped when done pulses.
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_i, start_i, flush_i, hi_we_i, lo_we_i;
    logic [1:0]   op_i;
    logic [W-1:0] a_i, b_i, wdata_i;
    logic         busy_o, done_o, div_zero_o;
    logic [W-1:0] hi_o, lo_o;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .op_i       (op_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .flush_i    (flush_i),
        .hi_we_i    (hi_we_i),
        .lo_we_i    (lo_we_i),
        .wdata_i    (wdata_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .div_zero_o (div_zero_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    typedef struct {
        string        tag;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
        int           t0;
    } exp_t;

    exp_t         exp_q[$];
    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    logic [W-1:0] m_hi  = '0;
    logic [W-1:0] m_lo  = '0;
    logic         m_dz  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: 64-bit arithmetic on sign/zero-extended operands.
    function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic dz_in, output logic [W-1:0] hi, output logic [W-1:0] lo,
                                  output logic dz, output int lat);
        logic [2*W-1:0]      p;
        logic signed [W-1:0] sa, sb;
        logic [W-1:0]        most_neg;
        sa       = a;
        sb       = b;
        most_neg = {1'b1, {(W-1){1'b0}}};
        dz       = dz_in;
        lat      = W + 1;
        hi       = '0;
        lo       = '0;
        case (op)
            2'b00: begin
                p  = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
                hi = p[2*W-1:W];
                lo = p[W-1:0];
            end
            2'b01: begin
                p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                hi = p[2*W-1:W];
                lo = p[W-1:0];
            end
            default: begin
                if (b == '0) begin
                    hi  = a;
                    lo  = '1;
                    dz  = 1'b1;
                    lat = 2;
                end else begin
                    dz = 1'b0;
                    if (op == 2'b11) begin
                        lo = a / b;
                        hi = a % b;
                    end else if (a == most_neg && b == '1) begin
                        lo = a;
                        hi = '0;
                    end else begin
                        lo = sa / sb;
                        hi = sa % sb;
                    end
                end
            end
        endcase
    endfunction

    always begin
        @(posedge clk);
        #1;
        if (done_o) begin
            if (exp_q.size() == 0) begin
                check("done_unexpected", done_o, 1'b0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.tag, "_hi"}, hi_o, e.hi);
                check({e.tag, "_lo"}, lo_o, e.lo);
                check({e.tag, "_dz"}, div_zero_o, e.dz);
                check({e.tag, "_lat"}, cyc - e.t0, e.lat);
            end
        end
    end

    // mode 0: plain; 1: MTHI together with start; 2: MTHI + start poked while busy.
    task automatic issue(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int mode);
        exp_t         e;
        int           busy_n;
        bit           seen;
        logic [W-1:0] prev_hi;
        @(posedge clk);
        #1;
        prev_hi = m_hi;
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        if (mode == 1) begin
            hi_we_i = 1'b1;
            wdata_i = 32'hCAFE_0001;
        end
        e.tag = tag;
        model(op, a, b, m_dz, e.hi, e.lo, e.dz, e.lat);
        e.t0 = cyc + 1;
        exp_q.push_back(e);
        m_hi = e.hi;
        m_lo = e.lo;
        m_dz = e.dz;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        hi_we_i = 1'b0;
        if (mode == 1) check({tag, "_mthi_with_start"}, hi_o, 32'hCAFE_0001);
        busy_n = 0;
        seen   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            if (mode == 2 && i == 4) begin
                hi_we_i = 1'b1;
                wdata_i = 32'hDEAD_BEEF;
                start_i = 1'b1;
                op_i    = ~op;
                a_i     = 32'h0000_0011;
                b_i     = 32'h0000_0003;
            end
            if (mode == 2 && i == 5) begin
                hi_we_i = 1'b0;
                start_i = 1'b0;
                check({tag, "_mthi_busy_ignored"}, hi_o, prev_hi);
            end
            if (busy_o) busy_n++;
            @(posedge clk);
            #1;
        end
        check({tag, "_done_seen"}, seen, 1'b1);
        check({tag, "_busy_cycles"}, busy_n, e.lat);
    endtask

    // Launch, then flush so that the flush edge is k+1 edges after the start edge.
    task automatic flush_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input int k);
        @(posedge clk);
        #1;
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (k) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_busy_pre"}, busy_o, 1'b1);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        check({tag, "_busy_post"}, busy_o, 1'b0);
        check({tag, "_hi"}, hi_o, m_hi);
        check({tag, "_lo"}, lo_o, m_lo);
        check({tag, "_dz"}, div_zero_o, m_dz);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]   r_op;
        logic [W-1:0] r_a, r_b;
        reset_i = 1'b1;
        start_i = 1'b0;
        flush_i = 1'b0;
        hi_we_i = 1'b0;
        lo_we_i = 1'b0;
        op_i    = 2'b00;
        a_i     = '0;
        b_i     = '0;
        wdata_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_dz", div_zero_o, 1'b0);
        check("rst_hi", hi_o, '0);
        check("rst_lo", lo_o, '0);
        reset_i = 1'b0;

        issue("mult_m3x7", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 0);
        check("plan_mult_lo", lo_o, 32'hFFFF_FFEB);
        issue("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        issue("divu_100_7", 2'b11, 32'd100, 32'd7, 0);
        issue("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0);
        issue("divu_5_0", 2'b11, 32'd5, 32'd0, 0);
        issue("divu_9_3", 2'b11, 32'd9, 32'd3, 0);
        issue("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        issue("div_m7_0", 2'b10, 32'hFFFF_FFF9, 32'd0, 0);
        issue("div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 0);
        issue("mult_min_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 0);

        flush_op("flush_calc", 2'b00, 32'd6, 32'd6, 9);
        flush_op("flush_fin", 2'b00, 32'd6, 32'd6, W);

        @(posedge clk);
        #1;
        start_i = 1'b1;
        flush_i = 1'b1;
        op_i    = 2'b01;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        flush_i = 1'b0;
        check("start_flush_idle_busy", busy_o, 1'b0);

        @(posedge clk);
        #1;
        lo_we_i = 1'b1;
        wdata_i = 32'h0000_1234;
        @(posedge clk);
        #1;
        lo_we_i = 1'b0;
        check("mtlo_lo", lo_o, 32'h0000_1234);
        check("mtlo_hi", hi_o, m_hi);
        m_lo = 32'h0000_1234;

        issue("mult_mthi_busy", 2'b00, 32'd6, 32'd6, 2);
        issue("multu_mthi_start", 2'b01, 32'd3, 32'd5, 1);

        for (int n = 0; n < 16; n++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            if ($urandom_range(0, 7) == 0) r_b = '0;
            else if ($urandom_range(0, 1) == 1) r_b = $urandom;
            else r_b = $urandom_range(1, 50);
            issue($sformatf("rnd%0d", n), r_op, r_a, r_b, 0);
        end

        @(posedge clk);
        #1;
        start_i = 1'b1;
        op_i    = 2'b00;
        a_i     = 32'd9;
        b_i     = 32'd9;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset_i = 1'b1;
        #1;
        check("midrst_busy", busy_o, 1'b0);
        check("midrst_hi", hi_o, '0);
        check("midrst_lo", lo_o, '0);
        check("midrst_dz", div_zero_o, 1'b0);
        m_hi = '0;
        m_lo = '0;
        m_dz = 1'b0;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        issue("post_rst_mult", 2'b00, 32'd6, 32'd6, 0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised iterative multiply/divide unit for the EX stage of the 5-stage pipeline. Sits beside the ALU.
- Executes MULT/MULTU/DIV/DIVU into private HI/LO registers and supports MTHI/MTLO writes.
- Drives `busy` so the hazard unit stalls PC, IF/ID and control while an operation is in flight.
- Successor to the single-cycle ALU path: data width is configurable, and it adds multi-cycle sequencing, abort and fault flags.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each; legal values are ≥4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  launch operation; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  WIDTH  rs operand (multiplicand / dividend)
- b  in  WIDTH  rt operand (multiplier / divisor)
- flush  in  1  abort in-flight operation (branch/jump flush)
- hi_we  in  1  MTHI write strobe
- lo_we  in  1  MTLO write strobe
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse; HI/LO were updated this edge
- div_zero  out  1  sticky: last division had b==0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset values (asynchronous): state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0.
- FSM states: IDLE → CALC → FIN → IDLE.
- IDLE:
  - start=1 latches |a|, |b|, the operand signs and op; counter ← WIDTH; go to CALC.
  - For unsigned ops, and for positive signed operands, the latched magnitude equals the raw operand.
- CALC, one iteration per cycle, counter decrements by 1:
  - Multiply: shift-add over a 2·WIDTH accumulator; the LSB of the multiplier decides whether to add.
  - Divide: restoring division; remainder is shifted left with the next dividend bit, the divisor is subtracted, and the quotient bit is set when the result is non-negative.
  - When counter reaches 0, go to FIN.
- FIN:
  - Apply sign correction. Product is negated if sign(a)≠sign(b). Quotient is negated if signs differ. Remainder takes the sign of a.
  - Write hi/lo, pulse done=1, return to IDLE.
- Latency: start sampled at edge N → done=1 and new hi/lo visible after edge N+WIDTH+1; busy=1 from edge N through edge N+WIDTH+1.
- Results:
  - Multiply: {hi,lo} = full 2·WIDTH product.
  - Divide: lo = quotient, hi = remainder.
- Divide by zero (DIV or DIVU with b==0):
  - No iteration: go directly to FIN the next cycle (latency 2).
  - lo = all ones, hi = a unchanged, div_zero=1.
  - div_zero is cleared by the next accepted DIV/DIVU with b≠0.
- Signed overflow (DIV with a = most-negative value, b = all ones): lo = a, hi = 0, no flag. This falls out naturally from the magnitude arithmetic plus sign correction; it is verified explicitly.
- start while busy: ignored; the hazard unit must not issue one.
- flush:
  - In CALC or FIN: return to IDLE next edge, no done, hi/lo and div_zero unchanged.
  - flush in IDLE together with start: start is dropped.
  - flush has priority over the FIN write.
- hi_we/lo_we:
  - Honoured only in IDLE; register ← wdata next edge.
  - If asserted together with start, the write takes effect and the later result overwrites it.
  - Ignored while busy.
- reset mid-operation: immediate return to the reset values above.

Optional Feature:
- MULDIV_EARLY_TERM_EN
- Defined: multiply leaves CALC as soon as the remaining multiplier bits are all zero. The accumulator is shifted by the remaining counter value in a single cycle. Latency becomes 2 + (index of highest set bit of |b|) + 1; with b==0 it is 2.
- Not defined: fixed WIDTH+1 latency for every multiply.
- Division is unaffected in both configurations.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU;
  - the state enum IDLE/CALC/FIN.
- One sub-module, muldiv_datapath, is natural: the accumulator, remainder and quotient shift registers plus the add/subtract step, controlled by the top-level FSM.

Test Plan (WIDTH=32):
- MULT a=0xFFFFFFFD (−3), b=7 → after 33 cycles done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 33 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIVU 100/7 → lo=14, hi=2. DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 5/0 → done after 2 cycles, lo=0xFFFFFFFF, hi=5, div_zero=1. Then DIVU 9/3 → div_zero=0, lo=3, hi=0.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- MULT 6*6 with flush asserted at cycle 10 → no done, hi/lo keep prior values, busy=0 the following cycle. Then MTLO wdata=0x1234 while IDLE → lo=0x1234. MTHI during a busy MULT → ignored.
